// File: rtl/bitwise_pkg.sv
// Shared definitions for the pipelined bitwise unit: opcode width and encodings.
package bitwise_pkg;

  localparam int unsigned OPW = 3;

  typedef enum logic [OPW-1:0] {
    OP_AND  = 3'd0,
    OP_OR   = 3'd1,
    OP_XOR  = 3'd2,
    OP_NAND = 3'd3,
    OP_NOR  = 3'd4,
    OP_XNOR = 3'd5,
    OP_NOTA = 3'd6,
    OP_PASS = 3'd7
  } op_e;

endpackage

// File: rtl/bitwise_lane_op.sv
// Combinational WIDTH-bit bitwise operator: selects one of eight per-bit functions of a and b.
module bitwise_lane_op
  import bitwise_pkg::*;
#(
  parameter int unsigned WIDTH = 16
) (
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  op_e              op_i,
  output logic [WIDTH-1:0] res_o
);

  // Opcode mux; every encoding is defined so the default only guards against X.
  always_comb begin
    res_o = '0;
    case (op_i)
      OP_AND:  res_o = a_i & b_i;
      OP_OR:   res_o = a_i | b_i;
      OP_XOR:  res_o = a_i ^ b_i;
      OP_NAND: res_o = ~(a_i & b_i);
      OP_NOR:  res_o = ~(a_i | b_i);
      OP_XNOR: res_o = ~(a_i ^ b_i);
      OP_NOTA: res_o = ~a_i;
      OP_PASS: res_o = a_i;
      default: res_o = '0;
    endcase
  end

endmodule

// File: rtl/bitwise_unit_pipe.sv
// Two-stage stallable bitwise logic unit with valid/ready on both sides.
// S1 captures operands, S2 registers the result and zero flag.
// Optional macro BITWISE_POPCOUNT_EN adds a registered set-bit count output (out_pop).
module bitwise_unit_pipe
  import bitwise_pkg::*;
#(
  parameter int unsigned WIDTH = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [WIDTH-1:0]              in_a,
  input  logic [WIDTH-1:0]              in_b,
  input  logic [OPW-1:0]                in_op,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [WIDTH-1:0]              out_res,
`ifdef BITWISE_POPCOUNT_EN
  output logic [$clog2(WIDTH+1)-1:0]    out_pop,
`endif
  output logic                          out_zero
);

  logic             s1_valid_q, s1_valid_d;
  logic [WIDTH-1:0] s1_a_q, s1_a_d;
  logic [WIDTH-1:0] s1_b_q, s1_b_d;
  op_e              s1_op_q, s1_op_d;

  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] out_res_q, out_res_d;
  logic             out_zero_q, out_zero_d;

  logic             s2_adv;
  logic             s1_adv;
  logic [WIDTH-1:0] lane_res;

  // A stage may advance when it is empty or the stage after it is moving.
  assign s2_adv   = !out_valid_q || out_ready;
  assign s1_adv   = !s1_valid_q || s2_adv;
  assign in_ready = s1_adv;

  bitwise_lane_op #(.WIDTH(WIDTH)) u_lane (
    .a_i   (s1_a_q),
    .b_i   (s1_b_q),
    .op_i  (s1_op_q),
    .res_o (lane_res)
  );

`ifdef BITWISE_POPCOUNT_EN
  localparam int unsigned PW = $clog2(WIDTH + 1);
  logic [PW-1:0] pop_d, out_pop_q;

  // Set-bit count of the value about to enter S2.
  always_comb begin
    pop_d = '0;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      pop_d = pop_d + PW'(lane_res[i]);
    end
  end

  // Popcount register shares the S2 load/hold/reset behaviour of out_res.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_pop_q <= '0;
    end else if (s2_adv && s1_valid_q) begin
      out_pop_q <= pop_d;
    end
  end

  assign out_pop = out_pop_q;
`endif

  // S1 next state: load a new beat when advancing, otherwise hold.
  always_comb begin
    s1_valid_d = s1_valid_q;
    s1_a_d     = s1_a_q;
    s1_b_d     = s1_b_q;
    s1_op_d    = s1_op_q;
    if (s1_adv) begin
      s1_valid_d = in_valid;
      if (in_valid) begin
        s1_a_d  = in_a;
        s1_b_d  = in_b;
        s1_op_d = op_e'(in_op);
      end
    end
  end

  // S2 next state: take the S1 result when advancing; bubbles keep the old data.
  always_comb begin
    out_valid_d = out_valid_q;
    out_res_d   = out_res_q;
    out_zero_d  = out_zero_q;
    if (s2_adv) begin
      out_valid_d = s1_valid_q;
      if (s1_valid_q) begin
        out_res_d  = lane_res;
        out_zero_d = (lane_res == '0);
      end
    end
  end

  // Pipeline registers; reset drops every in-flight beat.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_q  <= 1'b0;
      s1_a_q      <= '0;
      s1_b_q      <= '0;
      s1_op_q     <= OP_AND;
      out_valid_q <= 1'b0;
      out_res_q   <= '0;
      out_zero_q  <= 1'b1;
    end else begin
      s1_valid_q  <= s1_valid_d;
      s1_a_q      <= s1_a_d;
      s1_b_q      <= s1_b_d;
      s1_op_q     <= s1_op_d;
      out_valid_q <= out_valid_d;
      out_res_q   <= out_res_d;
      out_zero_q  <= out_zero_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_res   = out_res_q;
  assign out_zero  = out_zero_q;

endmodule

// File: tb/tb_bitwise_unit_pipe.sv
// Self-checking bench for bitwise_unit_pipe: directed table, backpressure,
// mid-stream reset and randomised WIDTH=33 / WIDTH=1 instances.
module tb_bitwise_unit_pipe;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Main 16-bit instance
  logic        in_valid, in_ready, out_valid, out_ready, out_zero;
  logic [15:0] in_a, in_b, out_res;
  logic [2:0]  in_op;
`ifdef BITWISE_POPCOUNT_EN
  logic [4:0]  out_pop;
`endif

  bitwise_unit_pipe #(.WIDTH(16)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_op(in_op),
    .out_valid(out_valid), .out_ready(out_ready), .out_res(out_res),
`ifdef BITWISE_POPCOUNT_EN
    .out_pop(out_pop),
`endif
    .out_zero(out_zero)
  );

  // WIDTH=33 instance
  logic        w_iv, w_ir, w_ov, w_or, w_z;
  logic [32:0] w_a, w_b, w_res;
  logic [2:0]  w_op;
`ifdef BITWISE_POPCOUNT_EN
  logic [5:0]  w_pop;
`endif

  bitwise_unit_pipe #(.WIDTH(33)) u_w33 (
    .clk(clk), .rst(rst),
    .in_valid(w_iv), .in_ready(w_ir),
    .in_a(w_a), .in_b(w_b), .in_op(w_op),
    .out_valid(w_ov), .out_ready(w_or), .out_res(w_res),
`ifdef BITWISE_POPCOUNT_EN
    .out_pop(w_pop),
`endif
    .out_zero(w_z)
  );

  // WIDTH=1 instance
  logic       n_iv, n_ir, n_ov, n_or, n_z;
  logic [0:0] n_a, n_b, n_res;
  logic [2:0] n_op;
`ifdef BITWISE_POPCOUNT_EN
  logic [0:0] n_pop;
`endif

  bitwise_unit_pipe #(.WIDTH(1)) u_w1 (
    .clk(clk), .rst(rst),
    .in_valid(n_iv), .in_ready(n_ir),
    .in_a(n_a), .in_b(n_b), .in_op(n_op),
    .out_valid(n_ov), .out_ready(n_or), .out_res(n_res),
`ifdef BITWISE_POPCOUNT_EN
    .out_pop(n_pop),
`endif
    .out_zero(n_z)
  );

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  function automatic logic [63:0] model(input logic [63:0] a, input logic [63:0] b,
                                        input logic [2:0] op, input int w);
    logic [63:0] r;
    logic [63:0] m;
    m = (w >= 64) ? '1 : ((64'd1 << w) - 64'd1);
    case (op)
      3'd0:    r = a & b;
      3'd1:    r = a | b;
      3'd2:    r = a ^ b;
      3'd3:    r = ~(a & b);
      3'd4:    r = ~(a | b);
      3'd5:    r = ~(a ^ b);
      3'd6:    r = ~a;
      default: r = a;
    endcase
    return r & m;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [15:0] a, input logic [15:0] b,
                       input logic [2:0] op, input logic ordy);
    in_valid  = v;
    in_a      = a;
    in_b      = b;
    in_op     = op;
    out_ready = ordy;
    #1;
  endtask

  // Collect accepted results of the main instance while enabled
  logic mon_en = 1'b0;
  logic [15:0] got_q[$];
  always @(posedge clk) begin
    if (mon_en && !rst && out_valid && out_ready) got_q.push_back(out_res);
  end

  // Scoreboards for the random-width instances
  logic [63:0] q33[$];
  logic [63:0] q1[$];
  always @(posedge clk) begin
    if (!rst && w_ov && w_or) begin
      if (q33.size() == 0) check("w33_unexpected_beat", 64'(q33.size()), 64'd1);
      else begin
        logic [63:0] e;
        e = q33.pop_front();
        check("w33_res", 64'(w_res), e);
        check("w33_zero", 64'(w_z), 64'(e == 64'd0));
      end
    end
    if (!rst && n_ov && n_or) begin
      if (q1.size() == 0) check("w1_unexpected_beat", 64'(q1.size()), 64'd1);
      else begin
        logic [63:0] e;
        e = q1.pop_front();
        check("w1_res", 64'(n_res), e);
        check("w1_zero", 64'(n_z), 64'(e == 64'd0));
      end
    end
  end

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic [2:0]  op;
    logic [15:0] res;
    logic        zero;
  } vec_t;

  localparam int NV = 12;
  vec_t tbl [NV];

  logic [15:0] bp_a   [4];
  logic [15:0] bp_b   [4];
  logic [2:0]  bp_op  [4];
  logic [15:0] bp_exp [4];
  logic [15:0] exp_q[$];

  initial begin
    // Directed vectors: op sweep, zero flag, and B-ignored / all-ones cases
    tbl[0]  = '{16'hF0F0, 16'hFF00, 3'd0, 16'hF000, 1'b0};
    tbl[1]  = '{16'hF0F0, 16'hFF00, 3'd1, 16'hFFF0, 1'b0};
    tbl[2]  = '{16'hF0F0, 16'hFF00, 3'd2, 16'h0FF0, 1'b0};
    tbl[3]  = '{16'hF0F0, 16'hFF00, 3'd3, 16'h0FFF, 1'b0};
    tbl[4]  = '{16'hF0F0, 16'hFF00, 3'd4, 16'h000F, 1'b0};
    tbl[5]  = '{16'hF0F0, 16'hFF00, 3'd5, 16'hF00F, 1'b0};
    tbl[6]  = '{16'hF0F0, 16'hFF00, 3'd6, 16'h0F0F, 1'b0};
    tbl[7]  = '{16'hF0F0, 16'hFF00, 3'd7, 16'hF0F0, 1'b0};
    tbl[8]  = '{16'hAAAA, 16'h5555, 3'd0, 16'h0000, 1'b1};
    tbl[9]  = '{16'hAAAA, 16'h5555, 3'd2, 16'hFFFF, 1'b0};
    tbl[10] = '{16'h0000, 16'h1234, 3'd4, 16'hEDCB, 1'b0};
    tbl[11] = '{16'hFFFF, 16'h1234, 3'd6, 16'h0000, 1'b1};

    bp_a   = '{16'h1234, 16'hABCD, 16'h0F0F, 16'hFFFF};
    bp_b   = '{16'h00FF, 16'h1111, 16'hF0F0, 16'h0001};
    bp_op  = '{3'd2, 3'd1, 3'd0, 3'd5};
    bp_exp = '{16'h12CB, 16'hBBDD, 16'h0000, 16'h0001};

    rst = 1'b1;
    in_valid = 1'b0; in_a = '0; in_b = '0; in_op = '0; out_ready = 1'b1;
    w_iv = 1'b0; w_a = '0; w_b = '0; w_op = '0; w_or = 1'b1;
    n_iv = 1'b0; n_a = '0; n_b = '0; n_op = '0; n_or = 1'b1;

    // Reset held three cycles, then released
    repeat (3) tick();
    check("rst_hold_out_valid", 64'(out_valid), 64'd0);
    rst = 1'b0;
    tick();
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_out_res", 64'(out_res), 64'd0);
    check("rst_out_zero", 64'(out_zero), 64'd1);
    check("rst_in_ready", 64'(in_ready), 64'd1);
`ifdef BITWISE_POPCOUNT_EN
    check("rst_out_pop", 64'(out_pop), 64'd0);
`endif

    // Table vectors back-to-back; result of vector i is visible after the 2nd edge
    for (int cyc = 0; cyc < NV + 1; cyc++) begin
      if (cyc < NV) drive(1'b1, tbl[cyc].a, tbl[cyc].b, tbl[cyc].op, 1'b1);
      else          drive(1'b0, 16'h0, 16'h0, 3'd0, 1'b1);
      check("tbl_in_ready", 64'(in_ready), 64'd1);
      @(posedge clk); #1;
      if (cyc >= 1) begin
        check($sformatf("tbl%0d_valid", cyc - 1), 64'(out_valid), 64'd1);
        check($sformatf("tbl%0d_res", cyc - 1), 64'(out_res), 64'(tbl[cyc-1].res));
        check($sformatf("tbl%0d_zero", cyc - 1), 64'(out_zero), 64'(tbl[cyc-1].zero));
`ifdef BITWISE_POPCOUNT_EN
        check($sformatf("tbl%0d_pop", cyc - 1), 64'(out_pop), 64'($countones(tbl[cyc-1].res)));
`endif
      end
    end
    drive(1'b0, 16'h0, 16'h0, 3'd0, 1'b1);
    tick();
    check("tbl_drained", 64'(out_valid), 64'd0);

    // Backpressure: 4 beats, consumer stalls 3 cycles after the first result
    mon_en = 1'b1;
    begin
      int idx;
      idx = 0;
      for (int cyc = 0; cyc < 20; cyc++) begin
        logic ordy;
        ordy = !(cyc >= 2 && cyc <= 4);
        if (idx < 4) drive(1'b1, bp_a[idx], bp_b[idx], bp_op[idx], ordy);
        else         drive(1'b0, 16'h0, 16'h0, 3'd0, ordy);
        if (cyc >= 2 && cyc <= 4) begin
          check("bp_in_ready_low", 64'(in_ready), 64'd0);
          check("bp_hold_valid", 64'(out_valid), 64'd1);
          check("bp_hold_res", 64'(out_res), 64'(bp_exp[0]));
        end
        if (in_valid && in_ready) begin
          exp_q.push_back(bp_exp[idx]);
          idx++;
        end
        @(posedge clk); #1;
      end
    end
    mon_en = 1'b0;
    check("bp_count", 64'(got_q.size()), 64'd4);
    for (int i = 0; i < 4; i++) begin
      if (i < got_q.size() && i < exp_q.size())
        check($sformatf("bp_beat%0d", i), 64'(got_q[i]), 64'(exp_q[i]));
    end

    // Reset with two beats in flight
    drive(1'b1, 16'h5A5A, 16'h00FF, 3'd1, 1'b0);
    tick();
    drive(1'b1, 16'h1111, 16'h2222, 3'd2, 1'b0);
    tick();
    check("mid_pre_valid", 64'(out_valid), 64'd1);
    rst = 1'b1;
    drive(1'b0, 16'h0, 16'h0, 3'd0, 1'b1);
    tick();
    check("mid_rst_valid", 64'(out_valid), 64'd0);
    check("mid_rst_res", 64'(out_res), 64'd0);
    check("mid_rst_zero", 64'(out_zero), 64'd1);
    check("mid_rst_in_ready", 64'(in_ready), 64'd1);
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("mid_no_stale", 64'(out_valid), 64'd0);
    end

    // Random beats on WIDTH=33 and WIDTH=1 with random backpressure
    begin
      int n33;
      int n1;
      n33 = 0;
      n1 = 0;
      for (int cyc = 0; cyc < 20000 && (n33 < 1000 || n1 < 1000); cyc++) begin
        w_iv = (n33 < 1000) && ($urandom_range(3) != 0);
        w_a  = 33'({$urandom(), $urandom()});
        w_b  = 33'({$urandom(), $urandom()});
        w_op = 3'($urandom_range(7));
        w_or = ($urandom_range(3) != 0);
        n_iv = (n1 < 1000) && ($urandom_range(3) != 0);
        n_a  = 1'($urandom_range(1));
        n_b  = 1'($urandom_range(1));
        n_op = 3'($urandom_range(7));
        n_or = ($urandom_range(3) != 0);
        #1;
        if (w_iv && w_ir) begin
          q33.push_back(model(64'(w_a), 64'(w_b), w_op, 33));
          n33++;
        end
        if (n_iv && n_ir) begin
          q1.push_back(model(64'(n_a), 64'(n_b), n_op, 1));
          n1++;
        end
        @(posedge clk); #1;
      end
      check("rand_w33_beats", 64'(n33), 64'd1000);
      check("rand_w1_beats", 64'(n1), 64'd1000);
    end
    w_iv = 1'b0; w_or = 1'b1;
    n_iv = 1'b0; n_or = 1'b1;
    repeat (5) tick();
    check("rand_w33_drained", 64'(q33.size()), 64'd0);
    check("rand_w1_drained", 64'(q1.size()), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
